// File: rtl/wb_arbiter_pkg.sv
// Shared constants and the writeback-entry type used by the arbiter and its load FIFO.
package wb_arbiter_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic              kill;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Bus between the ALU/load producers, the register-bank write port and decode's busy scoreboard.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] RW_dm_1;
    logic [DATA_W-1:0] ans_dm_1;
    logic              wb_we;
    logic [NREG-1:0]   busy;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  mem_ready, RW_dm_1, ans_dm_1, wb_we, busy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output mem_ready, RW_dm_1, ans_dm_1, wb_we, busy
    );
endinterface

// File: rtl/wb_arbiter_fifo.sv
// Load-result FIFO with per-entry kill-by-rd; killed entries keep their slot until popped.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [ADDR_W-1:0]             push_rd_i,
    input  logic [DATA_W-1:0]             push_data_i,
    input  logic                          pop_i,
    input  logic                          kill_i,
    input  logic [ADDR_W-1:0]             kill_rd_i,
    output wb_entry_t                     head_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [DEPTH-1:0]              ent_vld_o,
    output logic [DEPTH-1:0]              ent_kill_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_rd_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t [DEPTH-1:0] ent_q;
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [PW:0]           cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            // Kill is applied first so a same-cycle push (never matching) is unaffected.
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_i && ent_q[i].valid && ent_q[i].rd == kill_rd_i)
                    ent_q[i].kill <= 1'b1;
            end
            if (pop_i) begin
                ent_q[rd_ptr_q].valid <= 1'b0;
                rd_ptr_q              <= rd_ptr_q + PW'(1);
            end
            if (push_i) begin
                ent_q[wr_ptr_q] <= '{valid: 1'b1, kill: 1'b0, rd: push_rd_i, data: push_data_i};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = ent_q[rd_ptr_q];
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld_o[i]  = ent_q[i].valid;
            ent_kill_o[i] = ent_q[i].kill;
            ent_rd_o[i]   = ent_q[i].rd;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win the bank port, loads bypass or queue, busy tracks queued loads.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    wb_entry_t                    head;
    logic                         full, empty;
    logic [DEPTH-1:0]             ent_vld, ent_kill;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;

    logic              alu_win, accept, mem_live, push, pop;
    logic [ADDR_W-1:0] rw_d, rw_q;
    logic [DATA_W-1:0] ans_d, ans_q;
    logic              we_d, we_q;
    logic [NREG-1:0]   busy_d;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_rd_i   (bus.mem_rd),
        .push_data_i (bus.mem_data),
        .pop_i       (pop),
        .kill_i      (alu_win),
        .kill_rd_i   (bus.alu_rd),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .ent_vld_o   (ent_vld),
        .ent_kill_o  (ent_kill),
        .ent_rd_o    (ent_rd)
    );

    always_comb begin
        alu_win  = bus.alu_valid && (bus.alu_rd != REG_ZERO);
        accept   = bus.mem_valid && !full;
        // A same-rd load in the ALU's cycle is older and would be overwritten: drop it.
        mem_live = accept && (bus.mem_rd != REG_ZERO) &&
                   !(alu_win && bus.mem_rd == bus.alu_rd);
        push  = 1'b0;
        pop   = 1'b0;
        rw_d  = REG_ZERO;
        ans_d = '0;
        we_d  = 1'b0;
        if (alu_win) begin
            rw_d  = bus.alu_rd;
            ans_d = bus.alu_data;
            we_d  = 1'b1;
            push  = mem_live;
        end else if (!empty) begin
            pop  = 1'b1;
            push = mem_live;
            if (head.valid && !head.kill) begin
                rw_d  = head.rd;
                ans_d = head.data;
                we_d  = 1'b1;
            end
        end else if (mem_live) begin
            rw_d  = bus.mem_rd;
            ans_d = bus.mem_data;
            we_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_q  <= REG_ZERO;
            ans_q <= '0;
            we_q  <= 1'b0;
        end else begin
            rw_q  <= rw_d;
            ans_q <= ans_d;
            we_q  <= we_d;
        end
    end

    always_comb begin
        busy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && !ent_kill[i])
                busy_d[ent_rd[i]] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    assign bus.mem_ready = !full;
    assign bus.RW_dm_1   = rw_q;
    assign bus.ans_dm_1  = ans_q;
    assign bus.wb_we     = we_q;
    assign bus.busy      = busy_d;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + random bench for wb_arbiter against a queue-based writeback model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        bit                kill;
    } ld_t;

    ld_t               q[$];
    int                n_chk  = 0;
    int                n_fail = 0;
    logic [DATA_W-1:0] dut_bank [NREG];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG-1:0] model_busy();
        logic [NREG-1:0] b = '0;
        foreach (q[i]) if (!q[i].kill && q[i].rd != 0) b[q[i].rd] = 1'b1;
        return b;
    endfunction

    task automatic set_in(input bit av, input int ard, input int adat,
                          input bit mv, input int mrd, input int mdat);
        bus.alu_valid = av;
        bus.alu_rd    = ADDR_W'(ard);
        bus.alu_data  = DATA_W'(adat);
        bus.mem_valid = mv;
        bus.mem_rd    = ADDR_W'(mrd);
        bus.mem_data  = DATA_W'(mdat);
    endtask

    // One clock: check state-derived outputs, predict the registered write, then compare it.
    task automatic cycle();
        logic [ADDR_W-1:0] erw;
        logic [DATA_W-1:0] eans;
        bit                ewe, acc, aw, ml;
        ld_t               e;
        chk("mem_ready", 64'(bus.mem_ready), 64'(q.size() < DEPTH));
        chk("busy", 64'(bus.busy), 64'(model_busy()));
        acc = bus.mem_valid && (q.size() < DEPTH);
        aw  = bus.alu_valid && bus.alu_rd != 0;
        ml  = acc && bus.mem_rd != 0 && !(aw && bus.mem_rd == bus.alu_rd);
        e   = '{rd: bus.mem_rd, data: bus.mem_data, kill: 1'b0};
        erw = '0; eans = '0; ewe = 1'b0;
        if (aw) begin
            erw = bus.alu_rd; eans = bus.alu_data; ewe = 1'b1;
            for (int i = 0; i < q.size(); i++) if (q[i].rd == bus.alu_rd) q[i].kill = 1'b1;
            if (ml) q.push_back(e);
        end else if (q.size() > 0) begin
            ld_t h = q.pop_front();
            if (!h.kill) begin erw = h.rd; eans = h.data; ewe = 1'b1; end
            if (ml) q.push_back(e);
        end else if (ml) begin
            erw = e.rd; eans = e.data; ewe = 1'b1;
        end
        @(posedge clk); #1;
        chk("RW_dm_1", 64'(bus.RW_dm_1), 64'(erw));
        chk("ans_dm_1", 64'(bus.ans_dm_1), 64'(eans));
        chk("wb_we", 64'(bus.wb_we), 64'(ewe));
        dut_bank[bus.RW_dm_1] = bus.ans_dm_1;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0);
        repeat (n) cycle();
    endtask

    initial begin
        foreach (dut_bank[i]) dut_bank[i] = '0;
        set_in(0, 0, 0, 0, 0, 0);

        // 1. reset then idle
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_RW", 64'(bus.RW_dm_1), 64'd0);
            chk("rst_we", 64'(bus.wb_we), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
        end
        rst = 1'b0;
        idle(5);

        // 2. lone load bypass
        set_in(0, 0, 0, 1, 5, 'h1234);
        cycle();
        idle(2);

        // 3. conflict and drain
        set_in(1, 3, 'hAAAA, 1, 7, 'h5555);
        cycle();
        chk("busy7_set", 64'(bus.busy[7]), 64'd1);
        idle(3);

        // 4. backpressure: ALU every cycle, three loads offered
        set_in(1, 1, 'h0101, 1, 10, 'hA0A0); cycle();
        set_in(1, 2, 'h0202, 1, 11, 'hB0B0); cycle();
        chk("bp_ready_low", 64'(bus.mem_ready), 64'd0);
        set_in(1, 4, 'h0404, 1, 12, 'hC0C0); cycle();
        set_in(1, 6, 'h0606, 0, 0, 0);       cycle();
        idle(4);
        chk("bp_bank11", 64'(dut_bank[11]), 64'hB0B0);

        // 5. WAW kill, then same-cycle drop
        set_in(1, 1, 'h0001, 1, 9, 'h1111); cycle();
        set_in(1, 9, 'h2222, 0, 0, 0);      cycle();
        chk("waw_busy9_clr", 64'(bus.busy[9]), 64'd0);
        idle(3);
        chk("waw_bank9", 64'(dut_bank[9]), 64'h2222);
        set_in(1, 9, 'h3333, 1, 9, 'h4444); cycle();
        idle(3);
        chk("same_bank9", 64'(dut_bank[9]), 64'h3333);

        // 6. async reset mid-drain with two entries buffered
        set_in(1, 1, 'h0011, 1, 20, 'hDEAD); cycle();
        set_in(1, 2, 'h0022, 1, 21, 'hBEEF); cycle();
        set_in(0, 0, 0, 0, 0, 0);
        #3 rst = 1'b1;
        #1;
        chk("arst_RW", 64'(bus.RW_dm_1), 64'd0);
        chk("arst_ans", 64'(bus.ans_dm_1), 64'd0);
        chk("arst_we", 64'(bus.wb_we), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
        chk("arst_bank20", 64'(dut_bank[20]), 64'd0);
        chk("arst_bank21", 64'(dut_bank[21]), 64'd0);

        // random traffic with narrow rd range to provoke collisions
        for (int n = 0; n < 1500; n++) begin
            set_in($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 16'hFFFF),
                   $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom_range(0, 16'hFFFF));
            cycle();
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
